seq_fixed_divider: RTL and testbench



---
 rtl/seq_fixed_divider_pkg.sv | 18 +
 rtl/seq_fixed_divider_if.sv | 32 +++
 rtl/seq_fixed_divider_step.sv | 26 ++
 rtl/seq_fixed_divider.sv | 130 +++++++++++++
 tb/tb_seq_fixed_divider.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/seq_fixed_divider_pkg.sv
// Shared types and default widths for the sequential fixed-point divider.
// The remainder output is enabled by defining DIV_REMAINDER_EN.
package div_pkg;

  localparam int unsigned DIV_IN_W    = 8;
  localparam int unsigned DIV_FRAC_W  = 8;
  localparam int unsigned DIV_MAX_Q_W = 64;

  // Saturated quotient reported for a zero divisor; sliced to the quotient width.
  localparam logic [DIV_MAX_Q_W-1:0] DIV_DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_fixed_divider_if.sv
// Operand/result handshake bundle for seq_fixed_divider.
// The rem signal exists only when DIV_REMAINDER_EN is defined.
interface seq_fixed_divider_if #(
  parameter int unsigned IN_W   = div_pkg::DIV_IN_W,
  parameter int unsigned FRAC_W = div_pkg::DIV_FRAC_W
) ();

  localparam int unsigned Q_W = IN_W + FRAC_W;

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] a;
  logic [IN_W-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [Q_W-1:0]  quot;
  logic            div_by_zero;
`ifdef DIV_REMAINDER_EN
  logic [IN_W-1:0] rem;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, quot, div_by_zero, rem);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, quot, div_by_zero, rem);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, quot, div_by_zero);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, quot, div_by_zero);
`endif

endinterface

// File: rtl/seq_fixed_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits.
module div_step #(
  parameter int unsigned IN_W = 8
) (
  input  logic [IN_W:0]   r,
  input  logic            n_bit,
  input  logic [IN_W-1:0] d,
  output logic [IN_W:0]   r_next_c,
  output logic            q_bit_c
);

  logic [IN_W+1:0] r_shift;

  // One spare MSB keeps the shifted remainder and compare free of overflow.
  always_comb begin
    r_shift = {r, n_bit};
    q_bit_c = (r_shift >= {2'b00, d});
    if (q_bit_c) begin
      r_next_c = (IN_W+1)'(r_shift - {2'b00, d});
    end else begin
      r_next_c = (IN_W+1)'(r_shift);
    end
  end

endmodule

// File: rtl/seq_fixed_divider.sv
// Iterative restoring divider: quot = floor((a << FRAC_W) / b), one bit per clock.
// Define DIV_REMAINDER_EN to expose the final remainder on the rem port.
module seq_fixed_divider
  import div_pkg::*;
#(
  parameter int unsigned IN_W   = DIV_IN_W,
  parameter int unsigned FRAC_W = DIV_FRAC_W
) (
  input logic               clk,
  input logic               rst_n,
  seq_fixed_divider_if.slave bus
);

  localparam int unsigned Q_W   = IN_W + FRAC_W;
  localparam int unsigned CNT_W = $clog2(Q_W);

  div_state_e       state_q, state_d;
  logic [Q_W-1:0]   n_q, n_d;
  logic [IN_W-1:0]  d_q, d_d;
  logic [IN_W:0]    r_q, r_d;
  logic [Q_W-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [IN_W:0]    step_r_c;
  logic             step_q_c;

  div_step #(.IN_W(IN_W)) u_step (
    .r        (r_q),
    .n_bit    (n_q[Q_W-1]),
    .d        (d_q),
    .r_next_c (step_r_c),
    .q_bit_c  (step_q_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      r_q         <= r_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    d_d         = d_q;
    r_d         = r_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          n_d        = {bus.a, {FRAC_W{1'b0}}};
          d_d        = bus.b;
          r_d        = '0;
          cnt_d      = CNT_W'(Q_W - 1);
          in_ready_d = 1'b0;
          if (bus.b == '0) begin
            state_d = DONE;
            quot_d  = DIV_DBZ_QUOT[Q_W-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = BUSY;
            quot_d  = '0;
            dbz_d   = 1'b0;
          end
        end
      end

      BUSY: begin
        n_d    = {n_q[Q_W-2:0], 1'b0};
        r_d    = step_r_c;
        quot_d = {quot_q[Q_W-2:0], step_q_c};
        if (cnt_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        // A zero-divisor result raises out_valid one cycle after entry.
        if (out_valid_q && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quot        = quot_q;
  assign bus.div_by_zero = dbz_q;
`ifdef DIV_REMAINDER_EN
  assign bus.rem         = r_q[IN_W-1:0];
`endif

endmodule

// File: tb/tb_seq_fixed_divider.sv
// Directed bench for seq_fixed_divider (8.8 and 12.4 builds); rem checked when
// DIV_REMAINDER_EN is defined.
module tb_seq_fixed_divider;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  seq_fixed_divider_if #(.IN_W(8),  .FRAC_W(8)) bus0 ();
  seq_fixed_divider_if #(.IN_W(12), .FRAC_W(4)) bus1 ();

  seq_fixed_divider #(.IN_W(8),  .FRAC_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_fixed_divider #(.IN_W(12), .FRAC_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sel=0 drives the 8.8 instance, sel=1 the 12.4 instance.
  task automatic do_op(input bit sel, input int a, input int b, input string tag);
    int frac, cyc, exp_q, exp_lat;
    frac    = sel ? 4 : 8;
    exp_q   = (b == 0) ? 32'h0000_FFFF : ((a << frac) / b);
    exp_lat = (b == 0) ? 1 : 16;
    if (sel) begin
      bus1.a = 12'(a); bus1.b = 12'(b); bus1.in_valid = 1'b1;
      check({tag, "_in_ready"}, 32'(bus1.in_ready), 32'd1);
    end else begin
      bus0.a = 8'(a); bus0.b = 8'(b); bus0.in_valid = 1'b1;
      check({tag, "_in_ready"}, 32'(bus0.in_ready), 32'd1);
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    cyc = 0;
    while (!(sel ? bus1.out_valid : bus0.out_valid) && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_quot"}, 32'(sel ? bus1.quot : bus0.quot), 32'(exp_q));
    check({tag, "_dbz"}, 32'(sel ? bus1.div_by_zero : bus0.div_by_zero), 32'(b == 0));
`ifdef DIV_REMAINDER_EN
    check({tag, "_rem"}, 32'(sel ? bus1.rem : 12'(bus0.rem)), (b == 0) ? 32'd0 : 32'((a << frac) % b));
`endif
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(sel ? bus1.out_valid : bus0.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(sel ? bus1.in_ready : bus0.in_ready), 32'd1);
  endtask

  initial begin
    int cyc, a, b;
    rst_n = 1'b1;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.a = '0; bus0.b = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus0.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_quot",      32'(bus0.quot), 32'd0);
    check("rst_dbz",       32'(bus0.div_by_zero), 32'd0);
    check("rst12_in_ready", 32'(bus1.in_ready), 32'd1);
    check("rst12_quot",     32'(bus1.quot), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(0, 128, 255, "a128_b255");
    do_op(0, 255, 1,   "a255_b1");
    do_op(0, 0,   7,   "a0_b7");
    do_op(0, 200, 200, "a200_b200");
    do_op(0, 10,  0,   "a10_b0");
    do_op(0, 1,   255, "a1_b255");

    // Backpressure: 77/5 -> 3942, held for 20 cycles with in_valid pulses.
    bus0.a = 8'd77; bus0.b = 8'd5; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    cyc = 0;
    while (!bus0.out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_latency", 32'(cyc), 32'd16);
    for (int i = 0; i < 20; i++) begin
      bus0.in_valid = 1'(i % 2);
      bus0.a = 8'($urandom_range(0, 255));
      bus0.b = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      check("bp_quot",      32'(bus0.quot), 32'd3942);
      check("bp_in_ready",  32'(bus0.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus0.out_valid), 32'd1);
    end
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus0.in_ready), 32'd1);
    check("bp_release_ov",       32'(bus0.out_valid), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("bp_no_capture_ov",    32'(bus0.out_valid), 32'd0);
    check("bp_no_capture_ready", 32'(bus0.in_ready), 32'd1);

    // Reset during BUSY discards the operation.
    bus0.a = 8'd255; bus0.b = 8'd1; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_busy_in_ready", 32'(bus0.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("mid_rst_quot",      32'(bus0.quot), 32'd0);
    check("mid_rst_in_ready",  32'(bus0.in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 3, 4, "post_rst_a3_b4");

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      do_op(0, a, b, "rnd8");
    end

    do_op(1, 4095, 1,    "w12_a4095_b1");
    do_op(1, 1000, 3,    "w12_a1000_b3");
    do_op(1, 4095, 4095, "w12_a4095_b4095");
    do_op(1, 77,   0,    "w12_b0");
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 4095);
      b = $urandom_range(1, 4095);
      do_op(1, a, b, "rnd12");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
